// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and constants for the register bank arbiter
//
// Contents:
//   state_e      : arbiter sequencer states (IDLE, ACC0, ACC1, RESP)
//   DW_DEF/AW_DEF: default data and address widths
//   PORT0/PORT1  : port-index constants, also the encoding of owner
package regbank_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/regbank_store.sv
// rtl/regbank_store.sv - DW x 2**AW register storage, synchronous write, cleared on reset
//
// Ports:
//   clk_i    : system clock
//   rstn_i   : synchronous active-low reset, clears every entry
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational view of the addressed entry)
module regbank_store
  import regbank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The arbiter registers this value into its per-port read data register.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - two-port arbiter and sequencer owning the SPP register bank
//
// Build option: REGBANK_ARB_RR_EN selects round-robin tie breaking;
// undefined selects fixed priority with port 0 winning every tie.
//
// Ports (x = 0, 1):
//   clk      : system clock
//   rst      : synchronous active-low reset
//   reqx     : access request (level, held until gntx is seen)
//   wex      : 1 = write, 0 = read
//   addrx    : entry address
//   wdatax   : write data
//   gntx     : access slot for port x active this cycle
//   rvalidx  : one-cycle pulse, rdatax carries new read data
//   rdatax   : read data, held until the next read by port x
//   busy     : access or response cycle in progress
//   owner    : port of the most recent grant
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          owner
);

  state_e        state_q;
  logic          gnt0_q, gnt1_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          busy_q;
  logic          owner_q;

  logic          tie_win;
  logic          win_d;
  logic          any_req;

  logic          st_we;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic [DW-1:0] st_rdata;

`ifdef REGBANK_ARB_RR_EN
  // On a tie, the port that did not get the last grant goes next.
  assign tie_win = ~owner_q;
`else
  assign tie_win = PORT0;
`endif

  assign any_req = req0 | req1;

  always_comb begin
    win_d = PORT0;
    if (req0 && req1) begin
      win_d = tie_win;
    end else if (req1) begin
      win_d = PORT1;
    end
  end

  // The storage port follows whichever requester owns the current ACC cycle.
  assign st_we    = ((state_q == ACC0) && we0) || ((state_q == ACC1) && we1);
  assign st_addr  = (state_q == ACC1) ? addr1  : addr0;
  assign st_wdata = (state_q == ACC1) ? wdata1 : wdata0;

  regbank_store #(
    .DW (DW),
    .AW (AW)
  ) u_store (
    .clk_i   (clk),
    .rstn_i  (rst),
    .we_i    (st_we),
    .waddr_i (st_addr),
    .wdata_i (st_wdata),
    .raddr_i (st_addr),
    .rdata_o (st_rdata)
  );

  // Every output is a register updated together with the state, so no
  // combinational path exists from any request input to a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
      owner_q   <= PORT1;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (any_req) begin
            state_q <= (win_d == PORT1) ? ACC1 : ACC0;
            gnt0_q  <= (win_d == PORT0);
            gnt1_q  <= (win_d == PORT1);
            owner_q <= win_d;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACC0: begin
          if (!we0) begin
            rdata0_q  <= st_rdata;
            rvalid0_q <= 1'b1;
          end
          state_q <= RESP;
          busy_q  <= 1'b1;
        end
        ACC1: begin
          if (!we1) begin
            rdata1_q  <= st_rdata;
            rvalid1_q <= 1'b1;
          end
          state_q <= RESP;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - self-checking bench for regbank_arbiter against a slot-level model
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, rvalid0, gnt1, rvalid1, busy, owner;
  logic [7:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  // Slot-level model: m_g is the port holding the access slot this cycle
  // (-1 none), m_resp marks the cycle after an access.
  int bank_m [4] = '{0, 0, 0, 0};
  int m_rd [2] = '{0, 0};
  bit m_rv [2] = '{0, 0};
  int m_g = -1;
  bit m_resp = 1'b0;
  int m_owner = 1;

  regbank_arbiter #(.DW(8), .AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .gnt0    (gnt0),
    .rvalid0 (rvalid0),
    .rdata0  (rdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .gnt1    (gnt1),
    .rvalid1 (rvalid1),
    .rdata1  (rdata1),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arb_m();
    if (req0 && req1) begin
`ifdef REGBANK_ARB_RR_EN
      return (m_owner == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return req0 ? 0 : 1;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      for (int i = 0; i < 4; i++) bank_m[i] = 0;
      m_rd[0] = 0; m_rd[1] = 0;
      m_rv[0] = 0; m_rv[1] = 0;
      m_owner = 1; m_g = -1; m_resp = 0;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (m_g >= 0) begin
        if (m_g == 0) begin
          if (we0) bank_m[addr0] = int'(wdata0);
          else begin m_rd[0] = bank_m[addr0]; m_rv[0] = 1; end
        end else begin
          if (we1) bank_m[addr1] = int'(wdata1);
          else begin m_rd[1] = bank_m[addr1]; m_rv[1] = 1; end
        end
        m_resp = 1; m_g = -1;
      end else begin
        m_resp = 0;
        if (req0 || req1) begin
          m_g = arb_m();
          m_owner = m_g;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("gnt0", 32'(gnt0), 32'(m_g == 0));
    chk("gnt1", 32'(gnt1), 32'(m_g == 1));
    chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
    chk("rdata0", 32'(rdata0), m_rd[0]);
    chk("rdata1", 32'(rdata1), m_rd[1]);
    chk("busy", 32'(busy), 32'((m_g >= 0) || m_resp));
    chk("owner", 32'(owner), m_owner);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input int a, input int d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = 2'(a); wdata0 = 8'(d); end
    else begin req1 = r; we1 = w; addr1 = 2'(a); wdata1 = 8'(d); end
  endtask

  // Request, wait for the grant, then release the request in the response cycle.
  task automatic do_access(input int p, input bit w, input int a, input int d);
    bit got;
    got = 0;
    set_port(p, 1'b1, w, a, d);
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      got = (p == 0) ? gnt0 : gnt1;
    end
    chk("acc_timeout", 32'(got), 32'd1);
    step();
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic new_req(input int p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 255)));
  endtask

  initial begin
    int k;
    int n0, n1;
    bit got;
    bit pend0, pend1;

    // Reset then idle
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("idle_owner", 32'(owner), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single write then read by port 0
    do_access(0, 1'b1, 2, 8'hA5);
    do_access(0, 1'b0, 2, 0);
    chk("wr_rd_rdata0", 32'(rdata0), 32'hA5);
    chk("wr_rd_rvalid0", 32'(rvalid0), 32'd1);

    // Cross-port coherence in the following slot
    do_access(1, 1'b1, 3, 8'h3C);
    do_access(0, 1'b0, 3, 0);
    chk("coherence_rdata0", 32'(rdata0), 32'h3C);

    // Back-to-back reads, address moves on after each grant
    for (int i = 0; i < 4; i++) do_access(1, 1'b1, i, 8'h11 * (i + 1));
    set_port(0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      got = 0;
      k = 0;
      while (!got && k < 8) begin
        step();
        k++;
        got = gnt0;
      end
      chk("b2b_latency", k, 1);
      step();
      chk("b2b_rvalid0", 32'(rvalid0), 32'd1);
      chk("b2b_rdata0", 32'(rdata0), 32'h11 * (i + 1));
      if (i < 3) addr0 = 2'(i + 1); else req0 = 1'b0;
    end
    step();

    // Tie: both ports request reads continuously
    set_port(0, 1'b1, 1'b0, 1, 0);
    set_port(1, 1'b1, 1'b0, 2, 0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n0 += int'(gnt0);
      n1 += int'(gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
`ifdef REGBANK_ARB_RR_EN
    chk("tie_gnt0_count", n0, 3);
    chk("tie_gnt1_count", n1, 3);
`else
    chk("tie_gnt0_count", n0, 6);
    chk("tie_gnt1_count", n1, 0);
`endif

    // Reset lands on the ACC1 cycle of a write
    set_port(1, 1'b1, 1'b1, 0, 8'hFF);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = gnt1;
    end
    chk("rst_mid_gnt1", 32'(got), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    req1 = 1'b0;
    step();
    chk("rst_mid_gnt1_after", 32'(gnt1), 32'd0);
    chk("rst_mid_rvalid1_after", 32'(rvalid1), 32'd0);
    do_access(0, 1'b0, 0, 0);
    chk("rst_mid_rdata0", 32'(rdata0), 32'd0);
    step();

    // Randomized traffic from both ports against the model
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (gnt0) pend0 = 1;
      else if (pend0) begin
        pend0 = 0;
        if ($urandom_range(0, 1) == 1) new_req(0); else req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 3) == 0) new_req(0);
      if (gnt1) pend1 = 1;
      else if (pend1) begin
        pend1 = 0;
        if ($urandom_range(0, 1) == 1) new_req(1); else req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 3) == 0) new_req(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-port arbiter and sequencer for the SPP 4-entry × 8-bit register bank.
- Shares the bank between port 0 (parallel-port access FSM) and port 1 (an on-board client such as a debug/display engine).
- Serialises their read/write requests through one access slot, owns the storage, and returns read data on a per-port valid strobe.
- Sits between the read/write FSM and the nibble/read output path, replacing direct decoder-to-register wiring.

## Interface
Parameters:
- DW, 8, data width of each bank entry
- AW, 2, address width; bank depth is 2**AW

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- req0  in  1  port 0 access request (level)
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 entry address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  port 0 access slot active this cycle
- rvalid0  out  1  port 0 read data valid (one-cycle pulse)
- rdata0  out  DW  port 0 read data, held until next port 0 read
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: identical set for port 1
- busy  out  1  an access or response cycle is in progress
- owner  out  1  port of the most recent grant

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: no request → stay. Requests present → arbitrate → ACC0 or ACC1.
- ACCx:
  - gntx=1.
  - Requester's we/addr/wdata are sampled this cycle.
  - Write: bank[addr] ← wdata at the edge ending ACCx.
  - Read: rdatax ← bank[addr] at the same edge.
  - Always → RESP.
- RESP:
  - rvalidx=1 if the preceding access was a read; no pulse on writes.
  - Arbitrate again: request present → ACCx directly; none → IDLE.
- Requesters must hold req/we/addr/wdata stable from assertion until gnt is seen.
- A req still high in RESP is a new access (back-to-back allowed).
- Arbitration with a single requester: that port wins.
- Arbitration tie: policy set by Configuration.
- owner updates on entry to ACCx; resets to 1, so port 0 wins the first tie.
- Read-after-write to the same entry by the other port in the next slot returns the new data.
- Address covers the whole bank; there are no out-of-range accesses.
- busy = (state != IDLE).

## Timing
- Reset (rst=0 at a rising edge):
  - State → IDLE.
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0, busy=0, owner=1.
  - All bank entries cleared to 0.
- Reset has priority over any access. An ACC cycle coinciding with reset performs no write and no read capture.
- All outputs are registered. No combinational path from req to gnt.
- Latency:
  - req asserted in IDLE at cycle n → gnt at n+1 → rvalid at n+2.
  - Peak throughput is one access per 2 cycles; both ports contending alternate ACC0/RESP/ACC1/RESP.
- Starvation bound (round-robin built): a waiting port is granted within 2 slots (4 cycles).

## Configuration
- REGBANK_ARB_RR_EN defined: round-robin. On a tie, the port not equal to owner wins.
- Undefined: fixed priority. Port 0 always wins a tie; port 1 may starve under continuous port 0 requests.

## Structure
- Shared package `regbank_pkg`:
  - state enum (IDLE, ACC0, ACC1, RESP)
  - default DW/AW constants
  - port-index constants PORT0=0, PORT1=1
- One sub-module: `regbank_store`. Synchronous DW×2**AW storage with a single write enable, write address and read address, cleared on reset.
- Arbitration, FSM and output registers live in regbank_arbiter.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 with no requests → all outputs 0, owner=1, busy=0 for 10 cycles.
- Single write/read: port 0 writes 0xA5 to addr 2, then reads addr 2 → gnt0 at n+1, rvalid0 at n+2 with rdata0=0xA5; no rvalid on the write.
- Tie: req0 and req1 asserted together and held → with REGBANK_ARB_RR_EN, grants alternate 0,1,0,1 every 2 cycles; without it, gnt1 never asserts while req0 is held.
- Cross-port coherence: port 1 writes 0x3C to addr 3, port 0 reads addr 3 in the next slot → rdata0=0x3C.
- Reset mid-access: port 1 writes 0xFF to addr 0, with rst=0 in its ACC1 cycle → a later read of addr 0 returns 0x00, and rvalid1/gnt1 are 0 the cycle after reset.
- Back-to-back: req0 held high with reads of addr 0..3 changing after each gnt → four rvalid0 pulses 2 cycles apart with the stored values.
